// File: rtl/box_config_ctrl.sv
// Bounding-box geometry controller for the VGA overlay.
// Pushbutton stepping (with auto-repeat) and host absolute writes land in shadow
// registers; the shadow is copied to the committed outputs on frame_start only.
module box_config_ctrl #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned W_MIN        = 5,
    parameter int unsigned W_MAX        = 160,
    parameter int unsigned H_MIN        = 5,
    parameter int unsigned H_MAX        = 120,
    parameter int unsigned CX_DEF       = 320,
    parameter int unsigned CY_DEF       = 240,
    parameter int unsigned W_DEF        = 160,
    parameter int unsigned H_DEF        = 120,
    parameter int unsigned REPEAT_DELAY = 2048,
    parameter int unsigned REPEAT_RATE  = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       mode_btn,
    input  logic       frame_start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_field,
    input  logic [9:0] cmd_value,
    output logic       cmd_err,
    output logic       mode,
    output logic [9:0] box_cx,
    output logic [9:0] box_cy,
    output logic [9:0] box_w,
    output logic [9:0] box_h,
    output logic       update_pending
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    // Limits held at 11 bits so +1/-1 at the edges of the 10-bit range cannot wrap.
    localparam logic [10:0] CX_HI = 11'(H_ACTIVE - 1);
    localparam logic [10:0] CY_HI = 11'(V_ACTIVE - 1);
    localparam logic [10:0] W_LO  = 11'(W_MIN);
    localparam logic [10:0] W_HI  = 11'(W_MAX);
    localparam logic [10:0] H_LO  = 11'(H_MIN);
    localparam logic [10:0] H_HI  = 11'(H_MAX);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_t;

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [9:0]         r_cx_q, r_cy_q, r_w_q, r_h_q;
    logic [9:0]         w_cx_d, w_cy_d, w_w_d, w_h_d;
    logic [9:0]         r_box_cx_q, r_box_cy_q, r_box_w_q, r_box_h_q;
    logic               r_mode_q, r_mode_btn_q, r_err_q, r_pending_q;
    logic               w_any, w_cmd_acc, w_step, w_write, w_err, w_mode_d;

    // Saturating +/-1; opposing buttons on one axis cancel.
    function automatic logic [9:0] step_axis(input logic [9:0] val, input logic inc,
                                             input logic dec, input logic [10:0] lo,
                                             input logic [10:0] hi);
        logic [10:0] v;
        v = {1'b0, val};
        if (inc && !dec) begin
            step_axis = (v >= hi) ? hi[9:0] : 10'(v + 11'd1);
        end else if (dec && !inc) begin
            step_axis = (v <= lo) ? lo[9:0] : 10'(v - 11'd1);
        end else begin
            step_axis = val;
        end
    endfunction

    // Clamp an absolute host value into [lo, hi].
    function automatic logic [9:0] clamp_val(input logic [9:0] val, input logic [10:0] lo,
                                             input logic [10:0] hi);
        logic [10:0] v;
        v = {1'b0, val};
        if (v < lo) begin
            clamp_val = lo[9:0];
        end else if (v > hi) begin
            clamp_val = hi[9:0];
        end else begin
            clamp_val = val;
        end
    endfunction

    assign w_any     = btn_up | btn_down | btn_left | btn_right;
    assign cmd_ready = rst_n && (r_state_q == StIdle);
    assign w_cmd_acc = cmd_valid && cmd_ready;

    // Button FSM next state, host writes and button steps into the shadow copy.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_cx_d    = r_cx_q;
        w_cy_d    = r_cy_q;
        w_w_d     = r_w_q;
        w_h_d     = r_h_q;
        w_step    = 1'b0;
        w_err     = 1'b0;
        unique case (r_state_q)
            StIdle: begin
                // A host command wins over a simultaneous press; the press is retaken
                // next cycle if still held.
                if (w_cmd_acc) begin
                    unique case (cmd_field)
                        2'd0: begin
                            w_cx_d = clamp_val(cmd_value, 11'd0, CX_HI);
                            w_err  = ({1'b0, cmd_value} > CX_HI);
                        end
                        2'd1: begin
                            w_cy_d = clamp_val(cmd_value, 11'd0, CY_HI);
                            w_err  = ({1'b0, cmd_value} > CY_HI);
                        end
                        2'd2: begin
                            w_w_d = clamp_val(cmd_value, W_LO, W_HI);
                            w_err = ({1'b0, cmd_value} < W_LO) || ({1'b0, cmd_value} > W_HI);
                        end
                        default: begin
                            w_h_d = clamp_val(cmd_value, H_LO, H_HI);
                            w_err = ({1'b0, cmd_value} < H_LO) || ({1'b0, cmd_value} > H_HI);
                        end
                    endcase
                end else if (w_any) begin
                    w_step    = 1'b1;
                    w_cnt_d   = CNT_W'(REPEAT_DELAY - 1);
                    w_state_d = StDelay;
                end
            end
            StDelay, StRepeat: begin
                if (!w_any) begin
                    w_state_d = StIdle;
                end else if (r_cnt_q == '0) begin
                    w_step    = 1'b1;
                    w_cnt_d   = CNT_W'(REPEAT_RATE - 1);
                    w_state_d = StRepeat;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_step) begin
            if (!r_mode_q) begin
                w_w_d = step_axis(r_w_q, btn_right, btn_left, W_LO, W_HI);
                w_h_d = step_axis(r_h_q, btn_up, btn_down, H_LO, H_HI);
            end else begin
                w_cx_d = step_axis(r_cx_q, btn_right, btn_left, 11'd0, CX_HI);
                w_cy_d = step_axis(r_cy_q, btn_down, btn_up, 11'd0, CY_HI);
            end
        end
    end

    assign w_write  = w_step | w_cmd_acc;
    // Mode edges are honoured only while the buttons do not own the resource.
    assign w_mode_d = r_mode_q ^ (mode_btn & ~r_mode_btn_q & (r_state_q == StIdle));

    // State, shadow and committed registers; commit copies the post-write shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q    <= StIdle;
            r_cnt_q      <= '0;
            r_cx_q       <= 10'(CX_DEF);
            r_cy_q       <= 10'(CY_DEF);
            r_w_q        <= 10'(W_DEF);
            r_h_q        <= 10'(H_DEF);
            r_box_cx_q   <= 10'(CX_DEF);
            r_box_cy_q   <= 10'(CY_DEF);
            r_box_w_q    <= 10'(W_DEF);
            r_box_h_q    <= 10'(H_DEF);
            r_mode_q     <= 1'b0;
            r_mode_btn_q <= mode_btn;
            r_err_q      <= 1'b0;
            r_pending_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_cx_q       <= w_cx_d;
            r_cy_q       <= w_cy_d;
            r_w_q        <= w_w_d;
            r_h_q        <= w_h_d;
            r_mode_q     <= w_mode_d;
            r_mode_btn_q <= mode_btn;
            r_err_q      <= w_err;
            if (frame_start) begin
                r_box_cx_q  <= w_cx_d;
                r_box_cy_q  <= w_cy_d;
                r_box_w_q   <= w_w_d;
                r_box_h_q   <= w_h_d;
                r_pending_q <= 1'b0;
            end else if (w_write) begin
                r_pending_q <= 1'b1;
            end
        end
    end

    assign cmd_err        = r_err_q;
    assign mode           = r_mode_q;
    assign box_cx         = r_box_cx_q;
    assign box_cy         = r_box_cy_q;
    assign box_w          = r_box_w_q;
    assign box_h          = r_box_h_q;
    assign update_pending = r_pending_q;

endmodule

// File: tb/tb_box_config_ctrl.sv
// Bench for box_config_ctrl: a cycle-level reference model compared on every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_box_config_ctrl;

    localparam int RD = 4;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       mode_btn = 1'b0, frame_start = 1'b0, cmd_valid = 1'b0;
    logic [1:0] cmd_field = 2'd0;
    logic [9:0] cmd_value = 10'd0;
    logic       cmd_ready, cmd_err, mode, update_pending;
    logic [9:0] box_cx, box_cy, box_w, box_h;

    box_config_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mode_btn(mode_btn), .frame_start(frame_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_field(cmd_field),
        .cmd_value(cmd_value), .cmd_err(cmd_err), .mode(mode),
        .box_cx(box_cx), .box_cy(box_cy), .box_w(box_w), .box_h(box_h),
        .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Reference model: fields indexed 0=cx 1=cy 2=w 3=h.
    int LO[4]  = '{0, 0, 5, 5};
    int HI[4]  = '{639, 479, 160, 120};
    int DEF[4] = '{320, 240, 160, 120};
    int m_sh[4];
    int m_cm[4];
    int m_t = -1;      // cycles a press has been held since its first step; -1 = idle
    int m_mode = 0;
    int m_err = 0;
    int m_pend = 0;
    int m_prev_mb = 0;
    int dx, dy, v;
    bit wr, idle, any, rise;

    function automatic int clampi(int x, int lo, int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic do_step();
        dx = int'(btn_right) - int'(btn_left);
        dy = int'(btn_down) - int'(btn_up);   // positive = downwards on screen
        if (m_mode == 0) begin
            m_sh[2] = clampi(m_sh[2] + dx, LO[2], HI[2]);
            m_sh[3] = clampi(m_sh[3] - dy, LO[3], HI[3]);
        end else begin
            m_sh[0] = clampi(m_sh[0] + dx, LO[0], HI[0]);
            m_sh[1] = clampi(m_sh[1] + dy, LO[1], HI[1]);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = DEF[i];
                m_cm[i] = DEF[i];
            end
            m_t = -1; m_mode = 0; m_err = 0; m_pend = 0;
            m_prev_mb = int'(mode_btn);
        end else begin
            wr = 1'b0;
            m_err = 0;
            idle = (m_t < 0);
            any = btn_up | btn_down | btn_left | btn_right;
            rise = mode_btn && (m_prev_mb == 0);
            if (idle) begin
                if (cmd_valid) begin
                    v = int'(cmd_value);
                    m_sh[cmd_field] = clampi(v, LO[cmd_field], HI[cmd_field]);
                    m_err = (v < LO[cmd_field] || v > HI[cmd_field]) ? 1 : 0;
                    wr = 1'b1;
                end else if (any) begin
                    do_step();
                    wr = 1'b1;
                    m_t = 0;
                end
            end else if (!any) begin
                m_t = -1;
            end else begin
                m_t++;
                if (m_t >= RD && (m_t - RD) % RR == 0) begin
                    do_step();
                    wr = 1'b1;
                end
            end
            if (rise && idle) m_mode = 1 - m_mode;
            m_prev_mb = int'(mode_btn);
            if (frame_start) begin
                for (int i = 0; i < 4; i++) m_cm[i] = m_sh[i];
                m_pend = 0;
            end else if (wr) begin
                m_pend = 1;
            end
        end
    end

    task automatic cmp(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model cx", int'(box_cx), m_cm[0]);
            cmp("model cy", int'(box_cy), m_cm[1]);
            cmp("model w", int'(box_w), m_cm[2]);
            cmp("model h", int'(box_h), m_cm[3]);
            cmp("model mode", int'(mode), m_mode);
            cmp("model cmd_err", int'(cmd_err), m_err);
            cmp("model pending", int'(update_pending), m_pend);
            cmp("model cmd_ready", int'(cmd_ready), (rst_n && m_t < 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] f, input logic [9:0] val);
        bit ok;
        ok = 1'b0;
        cmd_field = f;
        cmd_value = val;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_mis++;
            $display("FAIL cmd_ready timeout: got 0, expected 1 within 40 cycles");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // Reset defaults after a commit
        frame();
        cmp("reset cx", int'(box_cx), 320);
        cmp("reset cy", int'(box_cy), 240);
        cmp("reset w", int'(box_w), 160);
        cmp("reset h", int'(box_h), 120);
        cmp("reset mode", int'(mode), 0);
        cmp("reset ready", int'(cmd_ready), 1);
        cmp("reset pending", int'(update_pending), 0);

        // Right held 9 cycles: w already at its max
        btn_right = 1'b1;
        repeat (9) tick();
        btn_right = 1'b0;
        tick();
        frame();
        cmp("sat w max", int'(box_w), 160);

        // Left held 9 cycles: steps at 0,4,6,8 -> 156
        btn_left = 1'b1;
        repeat (9) tick();
        btn_left = 1'b0;
        tick();
        @(negedge clk);
        cmp("pending before frame", int'(update_pending), 1);
        cmp("w before frame", int'(box_w), 160);
        frame();
        cmp("w after repeat", int'(box_w), 156);
        cmp("pending after frame", int'(update_pending), 0);

        // Host writes with clamping
        send_cmd(2'd0, 10'd700);
        @(negedge clk);
        cmp("cx=700 err", int'(cmd_err), 1);
        tick();
        @(negedge clk);
        cmp("err one cycle", int'(cmd_err), 0);
        frame();
        cmp("cx clamped", int'(box_cx), 639);
        send_cmd(2'd3, 10'd2);
        @(negedge clk);
        cmp("h=2 err", int'(cmd_err), 1);
        frame();
        cmp("h clamped", int'(box_h), 5);
        send_cmd(2'd1, 10'd100);
        @(negedge clk);
        cmp("cy=100 err", int'(cmd_err), 0);
        frame();
        cmp("cy written", int'(box_cy), 100);

        // Command blocked while a button holds the resource
        btn_up = 1'b1;
        tick();
        cmd_field = 2'd1;
        cmd_value = 10'd200;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmp("ready low while held", int'(cmd_ready), 0);
        repeat (3) tick();
        btn_up = 1'b0;
        send_cmd(2'd1, 10'd200);

        // Simultaneous command and press: command first, step next cycle
        cmd_field = 2'd1;
        cmd_value = 10'd50;
        cmd_valid = 1'b1;
        btn_down = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        btn_down = 1'b0;
        tick();
        frame();
        cmp("simul cy", int'(box_cy), 50);
        cmp("simul h", int'(box_h), 5);

        // Mode toggle and position step
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        @(negedge clk);
        cmp("mode toggled", int'(mode), 1);
        send_cmd(2'd1, 10'd240);
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        tick();
        frame();
        cmp("cy tap up", int'(box_cy), 239);

        // Mode edge while busy is discarded
        btn_left = 1'b1;
        tick();
        mode_btn = 1'b1;
        tick();
        @(negedge clk);
        cmp("mode held busy", int'(mode), 1);
        btn_left = 1'b0;
        mode_btn = 1'b0;
        tick();

        // Opposing vertical buttons cancel, horizontal still steps
        send_cmd(2'd0, 10'd300);
        btn_up = 1'b1;
        btn_down = 1'b1;
        btn_right = 1'b1;
        tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_right = 1'b0;
        tick();
        frame();
        cmp("cx only", int'(box_cx), 301);
        cmp("cy unchanged", int'(box_cy), 239);

        // cx at 0 does not wrap on left
        send_cmd(2'd0, 10'd0);
        btn_left = 1'b1;
        tick();
        btn_left = 1'b0;
        tick();
        frame();
        cmp("cx floor", int'(box_cx), 0);

        // Reset mid-repeat
        btn_right = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        cmp("rst cx", int'(box_cx), 320);
        cmp("rst w", int'(box_w), 160);
        cmp("rst mode", int'(mode), 0);
        cmp("rst pending", int'(update_pending), 0);
        cmp("rst ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        btn_right = 1'b0;
        tick();
        tick();
        @(negedge clk);
        cmp("post rst ready", int'(cmd_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
